// File: rtl/spi_sfr_host.sv
// rtl/spi_sfr_host.sv - command-driven SFR sequencer for an SPI core; `define SPI_SFR_HOST_TIMEOUT_EN adds a SPIF poll timeout
module spi_sfr_host #(
  parameter int SS_GUARD    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_cfg,
  input  logic [7:0] cmd_data,
  input  logic [1:0] cmd_div,
  input  logic [2:0] cmd_sel,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic [1:0] sfraddr_w,
  output logic       sfrwe,
  output logic [7:0] spidata_o,
  output logic [2:0] sfraddr_r,
  input  logic [7:0] sfr_data_i,
  output logic [7:0] spssn_o
);

  typedef enum logic [3:0] {
    IDLE, WR_CR, WR_ER, SS_ON, WR_DR, POLL, RD_DR, SS_OFF, RSP
  } state_t;

  state_t     state, state_nx;
  logic [7:0] data_q;
  logic [1:0] div_q;
  logic [2:0] sel_q;
  logic [3:0] guard_q;
  logic [7:0] rx_q;
  logic [1:0] addr_w_q;
  logic [7:0] wdata_q;
  logic [2:0] addr_r_q;
  logic       accept, spif, guard_done, poll_expired, in_guard;

  assign accept     = cmd_valid && (state == IDLE);
  assign spif       = sfr_data_i[7];
  assign in_guard   = (state == SS_ON) || (state == SS_OFF);
  assign guard_done = (guard_q == 4'(SS_GUARD - 1));

`ifdef SPI_SFR_HOST_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        to_q;

  assign poll_expired = !spif && (tcnt_q == 16'(TIMEOUT_CYC - 1));
  assign rsp_timeout  = to_q;

  // WR_DR always precedes POLL, so clearing there is clearing on POLL entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state == WR_DR)     tcnt_q <= '0;
      else if (state == POLL) tcnt_q <= tcnt_q + 16'd1;
      if (accept)                                    to_q <= 1'b0;
      else if (state == POLL && !spif && poll_expired) to_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign poll_expired   = 1'b0;
  assign rsp_timeout    = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_data  = rx_q;
  assign spssn_o   = (state == SS_ON || state == WR_DR || state == POLL ||
                      state == RD_DR || state == SS_OFF) ? ~(8'd1 << sel_q) : 8'hFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      div_q    <= '0;
      sel_q    <= '0;
      guard_q  <= '0;
      rx_q     <= '0;
      addr_w_q <= '0;
      wdata_q  <= '0;
      addr_r_q <= '0;
    end else begin
      state    <= state_nx;
      addr_w_q <= sfraddr_w;
      wdata_q  <= spidata_o;
      addr_r_q <= sfraddr_r;
      guard_q  <= (in_guard && !guard_done) ? guard_q + 4'd1 : 4'd0;
      if (accept) begin
        data_q <= cmd_data;
        div_q  <= cmd_div;
        sel_q  <= cmd_sel;
        rx_q   <= '0;
      end else if (state == RD_DR) begin
        rx_q   <= sfr_data_i;
      end
    end
  end

  // SFR address/data outputs fall back to their registered copies so they hold between accesses
  always_comb begin
    state_nx  = state;
    sfrwe     = 1'b0;
    sfraddr_w = addr_w_q;
    spidata_o = wdata_q;
    sfraddr_r = addr_r_q;
    case (state)
      IDLE:   if (cmd_valid) state_nx = cmd_cfg ? WR_CR : SS_ON;
      WR_CR: begin
        sfrwe     = 1'b1;
        sfraddr_w = 2'd0;
        spidata_o = data_q;
        state_nx  = WR_ER;
      end
      WR_ER: begin
        sfrwe     = 1'b1;
        sfraddr_w = 2'd2;
        spidata_o = {6'b0, div_q};
        state_nx  = RSP;
      end
      SS_ON:  if (guard_done) state_nx = WR_DR;
      WR_DR: begin
        sfrwe     = 1'b1;
        sfraddr_w = 2'd3;
        spidata_o = data_q;
        state_nx  = POLL;
      end
      POLL: begin
        sfraddr_r = 3'd1;
        if (spif)              state_nx = RD_DR;
        else if (poll_expired) state_nx = SS_OFF;
      end
      RD_DR: begin
        sfraddr_r = 3'd3;
        state_nx  = SS_OFF;
      end
      SS_OFF: if (guard_done) state_nx = RSP;
      RSP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_sfr_host.sv
// tb/tb_spi_sfr_host.sv - scoreboard bench for spi_sfr_host with a behavioural SPI core model
module tb_spi_sfr_host;
  localparam int G  = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_cfg = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] cmd_div = 2'd0;
  logic [2:0] cmd_sel = 3'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [1:0] sfraddr_w;
  logic       sfrwe;
  logic [7:0] spidata_o;
  logic [2:0] sfraddr_r;
  logic [7:0] sfr_data_i;
  logic [7:0] spssn_o;

  spi_sfr_host #(.SS_GUARD(G), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfg(cmd_cfg),
    .cmd_data(cmd_data), .cmd_div(cmd_div), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .sfraddr_w(sfraddr_w), .sfrwe(sfrwe), .spidata_o(spidata_o),
    .sfraddr_r(sfraddr_r), .sfr_data_i(sfr_data_i), .spssn_o(spssn_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI core model: SPIF rises spif_delay cycles after an SPDR write
  logic       spif = 1'b0;
  int         sp_cnt = 0;
  int         spif_delay = 0;
  bit         spif_never = 1'b0;
  logic [7:0] slave_rx = 8'h00;

  assign sfr_data_i = (sfraddr_r == 3'd1) ? {spif, 7'b0} :
                      (sfraddr_r == 3'd3) ? slave_rx : 8'h00;

  always @(posedge clk) begin
    if (sfrwe && sfraddr_w == 2'd3) begin
      if (!spif_never && spif_delay == 0) spif <= 1'b1;
      else begin
        spif   <= 1'b0;
        sp_cnt <= spif_never ? 0 : spif_delay;
      end
    end else if (sp_cnt > 0) begin
      sp_cnt <= sp_cnt - 1;
      if (sp_cnt == 1) spif <= 1'b1;
    end
  end

  typedef struct packed { logic [1:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [7:0] d; logic to; } rsp_t;

  wr_t        wq[$];
  rsp_t       rq[$];
  logic [7:0] ssn_log[$];
  int         tests = 0;
  int         fails = 0;
  int         acc_cyc = 0;
  int         last_wr_cyc = 0;
  int         last_rsp_cyc = 0;
  int         rsp_cnt = 0;
  logic [7:0] prev_ssn = 8'hFF;

  task automatic cycle();
    wr_t  ew;
    rsp_t er;
    @(negedge clk);
    if (rst_n) begin
      if (sfrwe) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL sfr_write: got addr=%0d data=%02h, expected no write", sfraddr_w, spidata_o);
        end else begin
          ew = wq.pop_front();
          if (sfraddr_w !== ew.a || spidata_o !== ew.d) begin
            fails++;
            $display("FAIL sfr_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                     sfraddr_w, spidata_o, ew.a, ew.d);
          end
        end
        if (sfraddr_w == 2'd3) last_wr_cyc = cyc;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: got data=%02h timeout=%b, expected no response", rsp_data, rsp_timeout);
        end else begin
          er = rq.pop_front();
          if (rsp_data !== er.d || rsp_timeout !== er.to) begin
            fails++;
            $display("FAIL rsp_payload: got data=%02h timeout=%b, expected data=%02h timeout=%b",
                     rsp_data, rsp_timeout, er.d, er.to);
          end
        end
        tests++;
        if (cmd_ready !== 1'b0 || spssn_o !== 8'hFF) begin
          fails++;
          $display("FAIL rsp_state: got cmd_ready=%b spssn=%02h, expected 0 and ff", cmd_ready, spssn_o);
        end
      end
      tests++;
      if ($countones(~spssn_o) > 1) begin
        fails++;
        $display("FAIL ssn_onehot: got spssn=%02h, expected at most one low bit", spssn_o);
      end
      if (spssn_o != 8'hFF && spssn_o != prev_ssn) ssn_log.push_back(spssn_o);
      prev_ssn = spssn_o;
    end
  endtask

  task automatic send_cmd(input logic cfg, input logic [7:0] data, input logic [1:0] div,
                          input logic [2:0] sel, input logic [7:0] exp_rx, input logic exp_to,
                          input bit exp_rsp, input bit hold);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_cfg   = cfg;
    cmd_data  = data;
    cmd_div   = div;
    cmd_sel   = sel;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      cycle();
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL cmd_accept: got cmd_ready=%b, expected 1 within 3000 cycles", cmd_ready);
    end
    acc_cyc = cyc;
    if (cfg) begin
      wq.push_back({2'd0, data});
      wq.push_back({2'd2, {6'b0, div}});
    end else begin
      wq.push_back({2'd3, data});
    end
    if (exp_rsp) rq.push_back({exp_rx, exp_to});
    cycle();
    if (!hold) cmd_valid = 1'b0;
    cmd_data = ~data;
    cmd_div  = ~div;
    cmd_sel  = sel + 3'd5;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (rq.size() != 0 && n < limit) begin
      cycle();
      n++;
    end
    tests++;
    if (rq.size() != 0) begin
      fails++;
      $display("FAIL %s_rsp: got %0d responses pending, expected 0 within %0d cycles", name, rq.size(), limit);
    end
    cycle();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_ready: got cmd_ready=%b after rsp, expected 1", name, cmd_ready);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rsp: got ready=%b valid=%b to=%b data=%02h, expected 1 0 0 00",
               cmd_ready, rsp_valid, rsp_timeout, rsp_data);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (sfrwe !== 1'b0 || sfraddr_w !== 2'd0 || spidata_o !== 8'h00 || sfraddr_r !== 3'd0) begin
      fails++;
      $display("FAIL reset_sfr: got we=%b aw=%0d wd=%02h ar=%0d, expected 0 0 00 0",
               sfrwe, sfraddr_w, spidata_o, sfraddr_r);
    end
    tests++;
    if (spssn_o !== 8'hFF) begin
      fails++;
      $display("FAIL reset_ssn: got %02h, expected ff", spssn_o);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_configure();
    send_cmd(1'b1, 8'h50, 2'd3, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_done(50, "configure");
    tests++;
    if (last_rsp_cyc - acc_cyc !== 3) begin
      fails++;
      $display("FAIL cfg_latency: got %0d cycles, expected 3", last_rsp_cyc - acc_cyc);
    end
    tests++;
    if (sfraddr_w !== 2'd2 || spidata_o !== 8'h03) begin
      fails++;
      $display("FAIL cfg_hold: got addr=%0d data=%02h, expected 2 03", sfraddr_w, spidata_o);
    end
  endtask

  task automatic test_transfer();
    spif_never = 1'b0;
    spif_delay = 128;
    slave_rx   = 8'h3C;
    send_cmd(1'b0, 8'hA5, 2'd0, 3'd0, 8'h3C, 1'b0, 1'b1, 1'b0);
    tests++;
    if (spssn_o !== 8'hFE) begin
      fails++;
      $display("FAIL xfer_ssn: got %02h, expected fe", spssn_o);
    end
    wait_done(400, "transfer");
    tests++;
    if (last_wr_cyc - acc_cyc !== G + 1) begin
      fails++;
      $display("FAIL xfer_guard: got SPDR write %0d cycles after accept, expected %0d", last_wr_cyc - acc_cyc, G + 1);
    end
    tests++;
    if (sfraddr_r !== 3'd3) begin
      fails++;
      $display("FAIL xfer_rdhold: got sfraddr_r=%0d, expected 3", sfraddr_r);
    end
  endtask

  task automatic test_spif_immediate();
    spif_delay = 0;
    slave_rx   = 8'hC3;
    send_cmd(1'b0, 8'h0F, 2'd0, 3'd7, 8'hC3, 1'b0, 1'b1, 1'b0);
    tests++;
    if (spssn_o !== 8'h7F) begin
      fails++;
      $display("FAIL imm_ssn: got %02h, expected 7f", spssn_o);
    end
    wait_done(100, "spif_immediate");
    tests++;
    if (last_rsp_cyc - acc_cyc !== 2 * G + 4) begin
      fails++;
      $display("FAIL imm_latency: got %0d cycles, expected %0d", last_rsp_cyc - acc_cyc, 2 * G + 4);
    end
  endtask

  task automatic test_back_to_back();
    int         base = rsp_cnt;
    logic [7:0] one = 8'd1;
    logic [7:0] e;
    spif_delay = 5;
    slave_rx   = 8'h69;
    ssn_log.delete();
    for (int i = 0; i < 4; i++)
      send_cmd(1'b0, 8'h10 + 8'(i), 2'd0, 3'(i), 8'h69, 1'b0, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    wait_done(300, "back_to_back");
    tests++;
    if (rsp_cnt - base !== 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d responses, expected 4", rsp_cnt - base);
    end
    tests++;
    if (ssn_log.size() !== 4) begin
      fails++;
      $display("FAIL b2b_ssn_count: got %0d select patterns, expected 4", ssn_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = ~(one << i);
        tests++;
        if (ssn_log[i] !== e) begin
          fails++;
          $display("FAIL b2b_ssn_order: got %02h at slot %0d, expected %02h", ssn_log[i], i, e);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int base = rsp_cnt;
    spif_never = 1'b1;
    slave_rx   = 8'hEE;
`ifdef SPI_SFR_HOST_TIMEOUT_EN
    send_cmd(1'b0, 8'h3E, 2'd0, 3'd2, 8'h00, 1'b1, 1'b1, 1'b0);
    wait_done(200, "timeout");
    tests++;
    if (last_rsp_cyc - acc_cyc !== 2 * G + TO + 2 || rsp_cnt - base !== 1) begin
      fails++;
      $display("FAIL to_latency: got %0d cycles, %0d rsps, expected %0d cycles, 1 rsp",
               last_rsp_cyc - acc_cyc, rsp_cnt - base, 2 * G + TO + 2);
    end
`else
    send_cmd(1'b0, 8'h3E, 2'd0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2000) cycle();
    tests++;
    if (rsp_cnt !== base) begin
      fails++;
      $display("FAIL to_disabled: got %0d responses, expected 0 within 2000 cycles", rsp_cnt - base);
    end
    pulse_reset();
`endif
  endtask

  task automatic test_reset_mid_poll();
    int base = rsp_cnt;
    spif_never = 1'b1;
    send_cmd(1'b0, 8'h81, 2'd0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (G + 3) cycle();
    tests++;
    if (sfraddr_r !== 3'd1 || spssn_o !== 8'hEF) begin
      fails++;
      $display("FAIL rst_poll_entry: got ar=%0d spssn=%02h, expected 1 ef", sfraddr_r, spssn_o);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (spssn_o !== 8'hFF || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: got spssn=%02h ready=%b valid=%b, expected ff 1 0", spssn_o, cmd_ready, rsp_valid);
    end
    cycle();
    rst_n = 1'b1;
    repeat (300) cycle();
    tests++;
    if (rsp_cnt !== base || wq.size() != 0) begin
      fails++;
      $display("FAIL rst_no_rsp: got %0d responses %0d writes pending, expected 0 0", rsp_cnt - base, wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_configure();
    test_transfer();
    test_spif_immediate();
    test_back_to_back();
    test_timeout();
    test_reset_mid_poll();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_sfr_host.md
SPI_SFR_HOST -- requirements
Module: spi_sfr_host

Interface
REQ-001 Parameter: SS_GUARD, 2, clk cycles between slave-select edge and SFR data access (range 1..15).
REQ-002 Parameter: TIMEOUT_CYC, 1024, maximum SPIF poll cycles before abort (range 16..65535).
REQ-003 Port: clk  input  1  single clock, all logic on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: cmd_valid  input  1  command request.
REQ-006 Port: cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 Port: cmd_cfg  input  1  1 = configure, 0 = byte transfer.
REQ-008 Port: cmd_data  input  8  SPCR value (configure) or TX byte (transfer).
REQ-009 Port: cmd_div  input  2  SPER clock-divide code (configure only).
REQ-010 Port: cmd_sel  input  3  slave-select index (transfer only).
REQ-011 Port: rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 Port: rsp_data  output  8  received byte, valid with rsp_valid.
REQ-013 Port: rsp_timeout  output  1  transfer aborted, valid with rsp_valid.
REQ-014 Port: sfraddr_w  output  2  SFR write address (0 SPCR, 2 SPER, 3 SPDR).
REQ-015 Port: sfrwe  output  1  SFR write strobe.
REQ-016 Port: spidata_o  output  8  SFR write data.
REQ-017 Port: sfraddr_r  output  3  SFR read address (1 SPSR, 3 SPDR).
REQ-018 Port: sfr_data_i  input  8  SFR read data, combinational from sfraddr_r.
REQ-019 Port: spssn_o  output  8  active-low slave selects, driving the SPI core's spssn_i.

Function
REQ-020 Command fields are captured into internal registers on acceptance; later changes on the cmd_* inputs have no effect until the next acceptance.
REQ-021 FSM states: IDLE, WR_CR, WR_ER, SS_ON, WR_DR, POLL, RD_DR, SS_OFF, RSP.
REQ-022 Configure sequence: IDLE->WR_CR (sfrwe=1, sfraddr_w=0, spidata_o=cmd_data)->WR_ER (sfrwe=1, sfraddr_w=2, spidata_o={6'b0,cmd_div})->RSP->IDLE; rsp_valid asserts 3 cycles after acceptance with rsp_data=0.
REQ-023 Transfer sequence:
  - IDLE->SS_ON: spssn_o[cmd_sel]=0, all other bits 1.
  - SS_ON lasts SS_GUARD cycles, then WR_DR: one cycle, sfrwe=1, sfraddr_w=3, spidata_o=TX byte.
  - POLL: sfraddr_r=1; exit when sfr_data_i[7] (SPIF)=1.
  - RD_DR: one cycle, sfraddr_r=3; sfr_data_i registered as the RX byte.
  - SS_OFF lasts SS_GUARD cycles, then spssn_o=8'hFF -> RSP.
REQ-024 sfrwe is high only in WR_CR, WR_ER and WR_DR, for exactly one cycle each.
REQ-025 sfraddr_w, spidata_o and sfraddr_r hold their last values outside write/read states.
REQ-026 spssn_o is 8'hFF in every state except SS_ON, WR_DR, POLL, RD_DR and SS_OFF; at most one bit is low at any time.
REQ-027 rsp_valid is high for exactly one cycle in RSP; cmd_ready rises in the following cycle.
REQ-028 rsp_valid and cmd_ready are never high in the same cycle; a command presented while busy waits without loss.
REQ-029 If SPIF is already 1 on the first POLL cycle, the FSM exits POLL after that one cycle.

Reset
REQ-030 On rst_n low, asynchronously:
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_timeout=0, rsp_data=0.
  - sfrwe=0, sfraddr_w=0, spidata_o=0, sfraddr_r=0.
  - spssn_o=8'hFF, timeout counter=0.
REQ-031 Reset asserted mid-transfer releases spssn_o to 8'hFF immediately and produces no rsp_valid for the aborted command.

Configuration
REQ-032 Macro SPI_SFR_HOST_TIMEOUT_EN defined:
  - A 16-bit counter clears on POLL entry and increments each POLL cycle.
  - When it reaches TIMEOUT_CYC with SPIF=0, the FSM goes POLL->SS_OFF, skipping RD_DR.
  - Resulting RSP: rsp_timeout=1, rsp_data=0.
REQ-033 Macro undefined: no counter exists, POLL waits indefinitely, and rsp_timeout is tied to 0.

Verification
REQ-034 Configure: cmd_cfg=1, cmd_data=8'h50, cmd_div=3 -> write addr0=8'h50, then write addr2=8'h03, rsp_valid 3 cycles after acceptance.
REQ-035 Transfer: cmd_sel=0, cmd_data=8'hA5, slave model sets SPIF after 128 cycles and returns 8'h3C -> spssn_o=8'hFE, SPDR write of 8'hA5 after 2 guard cycles, rsp_data=8'h3C, spssn_o=8'hFF before rsp_valid.
REQ-036 Back-to-back: cmd_valid held high for 4 transfers with cmd_sel=0..3 -> 4 rsp_valid pulses, spssn_o low pattern FE, FD, FB, F7 in order, never overlapping.
REQ-037 Timeout (macro defined, TIMEOUT_CYC=16): SPIF never set -> rsp_timeout=1 and rsp_data=0 after 16 POLL cycles; macro undefined -> no rsp_valid within 2000 cycles.
REQ-038 Reset mid-POLL: rst_n low for 1 cycle -> spssn_o=8'hFF and cmd_ready=1 the same cycle, no rsp_valid afterwards.
